catch_round_ctrl: RTL and testbench

- Game-round sequencer for the two-glove catch game. It sits between the player controls and the ball state machine.
- Runs start countdown, serve, flight, miss penalty and game-over phases. Gates the ball state machine with play_enable and re-serves it with a ball_reset pulse.
- Tracks consecutive-catch score, best score and misses for the overlay/display logic. Timing is in video frames (vsync) on the 27 MHz vclock domain.

---
 rtl/catch_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_catch_round_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/catch_round_ctrl.sv
// Round sequencer for the two-glove catch game: countdown, serve,
// flight, miss penalty and game over, paced by vsync frame ticks.
module catch_round_ctrl #(
  parameter int FPS            = 60,
  parameter int COUNT_SEC      = 3,
  parameter int FLIGHT_TIMEOUT = 240,
  parameter int MISS_FRAMES    = 60,
  parameter int MAX_MISSES     = 3,
  parameter int SCORE_W        = 8
) (
  input  logic               vclock,
  input  logic               reset,
  input  logic               vsync,
  input  logic               start,
  input  logic               catch_event,
  input  logic               throw_event,
  output logic               play_enable,
  output logic               ball_reset,
  output logic [2:0]         game_state,
  output logic [1:0]         countdown_sec,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best,
  output logic [1:0]         misses
);

  localparam int MAX_AB  = (FPS > FLIGHT_TIMEOUT) ? FPS : FLIGHT_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > MISS_FRAMES) ? MAX_AB : MISS_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] FPS_END  = CW'(FPS - 1);
  localparam logic [CW-1:0] FLT_END  = CW'(FLIGHT_TIMEOUT - 1);
  localparam logic [CW-1:0] MISS_END = CW'(MISS_FRAMES - 1);
  localparam logic [1:0]    SEC_INIT = 2'(COUNT_SEC);
  localparam logic [1:0]    MISS_LIM = 2'(MAX_MISSES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_SERVE  = 3'd2,
    S_FLIGHT = 3'd3,
    S_MISS   = 3'd4,
    S_OVER   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         sec_q, sec_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [1:0]         miss_q, miss_d;
  logic               br_q, br_d;
  logic               pe_q, pe_d;
  logic               vsync_q, start_q;
  logic               frame_tick, start_rise;
  logic [SCORE_W-1:0] score_inc;
  logic [1:0]         miss_inc;

  assign frame_tick = vsync_q & ~vsync;
  assign start_rise = start & ~start_q;
  assign score_inc  = (&score_q) ? score_q : score_q + SCORE_W'(1);
  assign miss_inc   = miss_q + 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sec_d   = sec_q;
    score_d = score_q;
    best_d  = best_q;
    miss_d  = miss_q;
    br_d    = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          state_d = S_COUNT;
          score_d = '0;
          miss_d  = '0;
          sec_d   = SEC_INIT;
          cnt_d   = '0;
          br_d    = 1'b1;
        end
      end
      S_COUNT: begin
        if (frame_tick) begin
          if (cnt_q == FPS_END) begin
            cnt_d = '0;
            sec_d = sec_q - 2'd1;
            if (sec_q == 2'd1) state_d = S_SERVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_SERVE: begin
        if (throw_event) begin
          state_d = S_FLIGHT;
          cnt_d   = '0;
        end
      end
      S_FLIGHT: begin
        // a catch on the timeout frame still counts as a catch
        if (catch_event) begin
          state_d = S_SERVE;
          cnt_d   = '0;
          score_d = score_inc;
          if (score_inc > best_q) best_d = score_inc;
        end else if (frame_tick) begin
          if (cnt_q == FLT_END) begin
            score_d = '0;
            miss_d  = miss_inc;
            br_d    = 1'b1;
            cnt_d   = '0;
            state_d = (miss_inc == MISS_LIM) ? S_OVER : S_MISS;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_MISS: begin
        if (frame_tick) begin
          if (cnt_q == MISS_END) begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    pe_d = (state_d == S_SERVE) || (state_d == S_FLIGHT);
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sec_q   <= '0;
      score_q <= '0;
      best_q  <= '0;
      miss_q  <= '0;
      br_q    <= 1'b0;
      pe_q    <= 1'b0;
      vsync_q <= 1'b1;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sec_q   <= sec_d;
      score_q <= score_d;
      best_q  <= best_d;
      miss_q  <= miss_d;
      br_q    <= br_d;
      pe_q    <= pe_d;
      vsync_q <= vsync;
      start_q <= start;
    end
  end

  assign game_state    = state_q;
  assign play_enable   = pe_q;
  assign ball_reset    = br_q;
  assign countdown_sec = sec_q;
  assign score         = score_q;
  assign best          = best_q;
  assign misses        = miss_q;

endmodule

// File: tb/tb_catch_round_ctrl.sv
// Step-table bench for catch_round_ctrl with small frame timing
// and a queue holding the expected outputs of each applied step.
module tb_catch_round_ctrl;

  logic       vclock = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic       catch_event = 1'b0;
  logic       throw_event = 1'b0;
  logic       play_enable, ball_reset;
  logic [2:0] game_state;
  logic [1:0] countdown_sec, misses;
  logic [7:0] score, best;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 vclock = ~vclock;

  catch_round_ctrl #(
    .FPS(2), .COUNT_SEC(3), .FLIGHT_TIMEOUT(4),
    .MISS_FRAMES(2), .MAX_MISSES(3), .SCORE_W(8)
  ) dut (
    .vclock(vclock), .reset(reset), .vsync(vsync),
    .start(start), .catch_event(catch_event),
    .throw_event(throw_event), .play_enable(play_enable),
    .ball_reset(ball_reset), .game_state(game_state),
    .countdown_sec(countdown_sec), .score(score),
    .best(best), .misses(misses)
  );

  typedef struct {
    bit rst, tk, st, ca, th;
    int gs, pe, br, cd, sc, bs, ms;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(
    bit rst, bit tk, bit st, bit ca, bit th,
    int gs, int pe, int br, int cd, int sc, int bs, int ms);
    vec_t v;
    v.rst = rst; v.tk = tk; v.st = st; v.ca = ca; v.th = th;
    v.gs = gs; v.pe = pe; v.br = br; v.cd = cd;
    v.sc = sc; v.bs = bs; v.ms = ms;
    return v;
  endfunction

  task automatic cyc();
    @(posedge vclock);
    #1;
  endtask

  task automatic chk(input int idx, input string nm,
                     input logic [31:0] got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL step %0d %s: got %0d expected %0d",
               idx, nm, got, want);
    end
  endtask

  task automatic do_step(input int idx, input vec_t v);
    vec_t e;
    if (v.tk) begin
      vsync = 1'b1;
      repeat (96) cyc();
    end
    reset       = v.rst;
    start       = v.st;
    catch_event = v.ca;
    throw_event = v.th;
    vsync       = v.tk ? 1'b0 : 1'b1;
    sb.push_back(v);
    cyc();
    reset       = 1'b0;
    catch_event = 1'b0;
    throw_event = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL step %0d scoreboard empty", idx);
    end else begin
      e = sb.pop_front();
      chk(idx, "game_state", {29'd0, game_state}, e.gs);
      chk(idx, "play_enable", {31'd0, play_enable}, e.pe);
      chk(idx, "ball_reset", {31'd0, ball_reset}, e.br);
      chk(idx, "countdown_sec", {30'd0, countdown_sec}, e.cd);
      chk(idx, "score", {24'd0, score}, e.sc);
      chk(idx, "best", {24'd0, best}, e.bs);
      chk(idx, "misses", {30'd0, misses}, e.ms);
    end
    if (v.tk) begin
      repeat (3) cyc();
      vsync = 1'b1;
    end
  endtask

  initial begin
    // reset, then countdown 3 -> 0 over six ticks
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,3,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,3,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,2,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,2,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 2,1,0,0,0,0,0));
    // three throw / catch rounds
    for (int r = 1; r <= 3; r++) begin
      tbl.push_back(mk(0,0,1,0,1, 3,1,0,0,r-1,r-1,0));
      tbl.push_back(mk(0,1,1,0,0, 3,1,0,0,r-1,r-1,0));
      tbl.push_back(mk(0,1,1,0,0, 3,1,0,0,r-1,r-1,0));
      tbl.push_back(mk(0,0,1,1,0, 2,1,0,0,r,r,0));
    end
    tbl.push_back(mk(0,0,1,1,0, 2,1,0,0,3,3,0));
    // first drop and penalty, events ignored in MISS
    tbl.push_back(mk(0,0,1,0,1, 3,1,0,0,3,3,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,0,0, 3,1,0,0,3,3,0));
    tbl.push_back(mk(0,1,1,0,0, 4,0,1,0,0,3,1));
    tbl.push_back(mk(0,0,1,1,1, 4,0,0,0,0,3,1));
    tbl.push_back(mk(0,1,1,0,0, 4,0,0,0,0,3,1));
    tbl.push_back(mk(0,1,1,0,0, 2,1,0,0,0,3,1));
    // catch on the timeout tick wins
    tbl.push_back(mk(0,0,1,0,1, 3,1,0,0,0,3,1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,0,0, 3,1,0,0,0,3,1));
    tbl.push_back(mk(0,1,1,1,0, 2,1,0,0,1,3,1));
    // second drop, throw in flight ignored
    tbl.push_back(mk(0,0,1,0,1, 3,1,0,0,1,3,1));
    tbl.push_back(mk(0,0,1,0,1, 3,1,0,0,1,3,1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,0,0, 3,1,0,0,1,3,1));
    tbl.push_back(mk(0,1,1,0,0, 4,0,1,0,0,3,2));
    tbl.push_back(mk(0,1,1,0,0, 4,0,0,0,0,3,2));
    tbl.push_back(mk(0,1,1,0,0, 2,1,0,0,0,3,2));
    // third drop ends the game
    tbl.push_back(mk(0,0,1,0,1, 3,1,0,0,0,3,2));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,0,0, 3,1,0,0,0,3,2));
    tbl.push_back(mk(0,1,1,0,0, 5,0,1,0,0,3,3));
    tbl.push_back(mk(0,1,1,0,0, 5,0,0,0,0,3,3));
    // restart from OVER keeps best
    tbl.push_back(mk(0,0,0,0,0, 5,0,0,0,0,3,3));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,3,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,3,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,2,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,2,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,1,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,1,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, 2,1,0,0,0,3,0));
    tbl.push_back(mk(0,0,1,0,1, 3,1,0,0,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, 3,1,0,0,0,3,0));
    tbl.push_back(mk(0,0,1,1,0, 2,1,0,0,1,3,0));
    tbl.push_back(mk(0,0,1,0,1, 3,1,0,0,1,3,0));
    // reset in flight with start held: no press seen afterwards
    tbl.push_back(mk(1,0,1,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,1,3,0,0,0));

    repeat (2) cyc();
    foreach (tbl[i]) do_step(i + 1, tbl[i]);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
